spi_dac_writer: RTL

- Downstream SPI master for the diode-bias calibration path.
- Latches the 8-bit `voltage` word when the sweep controller pulses `spi_start`.
- Frames the word as a 16-bit DAC command and shifts it out MSB-first in SPI mode 0.
- Reports `busy`/`done` so the controller and debug logic can track DAC updates; flags dropped requests via `overrun`.

---
 rtl/spi_dac_writer_if.sv | 22 ++
 rtl/spi_dac_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_writer_if.sv
// Request/status and SPI pin bundle for spi_dac_writer.
// master: sweep controller side; slave: the DAC writer itself.
interface spi_dac_writer_if;
    logic       spi_start;
    logic [7:0] voltage;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output spi_start, voltage,
        input  spi_sclk, spi_mosi, spi_cs_n, busy, done, overrun
    );

    modport slave (
        input  spi_start, voltage,
        output spi_sclk, spi_mosi, spi_cs_n, busy, done, overrun
    );
endinterface

// File: rtl/spi_dac_writer.sv
// SPI mode-0 writer: frames {CMD_PREFIX, voltage} as 16 bits, MSB first, to the bias DAC.
// Define SPI_DAC_PENDING_EN to queue one request received while busy (latest wins).
module spi_dac_writer #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [7:0]  CMD_PREFIX = 8'h30,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input logic              clk,
    input logic              reset,
    spi_dac_writer_if.slave  bus
);

    localparam int unsigned DivW    = $clog2(CLK_DIV) + 1;
    localparam int unsigned WaitMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned WaitW   = $clog2(WaitMax) + 1;

    localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [WaitW-1:0] SetupLast = WaitW'(CS_SETUP - 1);
    localparam logic [WaitW-1:0] HoldLast  = WaitW'(CS_HOLD - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [15:0]      shift_q, shift_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic             start_frame;
    logic [7:0]       frame_data;

`ifdef SPI_DAC_PENDING_EN
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_q, pend_d;
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        wait_d    = wait_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;

`ifdef SPI_DAC_PENDING_EN
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        // A queued request takes priority over a fresh one arriving in the same idle cycle.
        start_frame  = (state_q == IDLE) && (pend_valid_q || bus.spi_start);
        frame_data   = pend_valid_q ? pend_q : bus.voltage;
        if ((state_q == IDLE) && pend_valid_q) begin
            pend_valid_d = 1'b0;
        end
        if (bus.spi_start && ((state_q != IDLE) || pend_valid_q)) begin
            overrun_d    = (state_q != IDLE) && pend_valid_q;
            pend_d       = bus.voltage;
            pend_valid_d = 1'b1;
        end
`else
        start_frame = (state_q == IDLE) && bus.spi_start;
        frame_data  = bus.voltage;
        if ((state_q != IDLE) && bus.spi_start) begin
            overrun_d = 1'b1;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (start_frame) begin
                    shift_d = {CMD_PREFIX, frame_data};
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (wait_q == SetupLast) begin
                    wait_d  = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DivLast) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Falling edge: present the next bit, or finish after the 16th.
                    if (sclk_q) begin
                        shift_d = {shift_q[14:0], 1'b0};
                        if (bit_q == 4'd15) begin
                            wait_d  = '0;
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (wait_q == HoldLast) begin
                    wait_d  = '0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            wait_q    <= '0;
            shift_q   <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            wait_q    <= wait_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SPI_DAC_PENDING_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end
`endif

    // MOSI is the shift register MSB, so it only moves when the register shifts on a fall.
    assign bus.spi_mosi = shift_q[15];
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_cs_n = cs_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;

endmodule
